// File: rtl/mem_wrapper_if.sv
// AXI4-Lite bundle: all five channels (aw, w, b, ar, r) for one master/slave pair.
// Latency: none, wires only.
// Backpressure: standard valid/ready on every channel.
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_wrapper.sv
// AXI4-Lite slave around a DEPTH x DW byte-writable memory, base address set by offset.
// Latency: bvalid one edge after AW and W are both held; rvalid one edge after the AR handshake.
// Backpressure: one transaction per direction; readies stay low until the B/R handshake completes.
module mem_wrapper #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi4_lite_if.slave    axi,
  input  logic [AW-1:0] offset
);

  localparam int SB = DW / 8;
  localparam int BS = (SB > 1) ? $clog2(SB) : 0;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Contents come up as zeros and are deliberately outside the reset domain.
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  logic          en_q;
  logic          aw_held_q, aw_held_d;
  logic [AW-1:0] awaddr_q,  awaddr_d;
  logic          w_held_q,  w_held_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic [SB-1:0] wstrb_q,   wstrb_d;
  logic          bvalid_q,  bvalid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic          ar_pend_q, ar_pend_d;
  logic [AW-1:0] araddr_q,  araddr_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [1:0]    rresp_q,   rresp_d;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          wr_ok, rd_ok, wr_commit;

  // Protection bits carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^{axi.awprot, axi.arprot};

  // Byte offset relative to the base (wraps modulo 2^AW), converted to a word index.
  assign wr_idx    = (awaddr_q - offset) >> BS;
  assign rd_idx    = (araddr_q - offset) >> BS;
  assign wr_ok     = (wr_idx < DEPTH_AW);
  assign rd_ok     = (rd_idx < DEPTH_AW);
  assign wr_commit = aw_held_q & w_held_q & ~bvalid_q;

  // en_q keeps every ready low until the first edge after reset release.
  assign axi.awready = en_q & ~aw_held_q;
  assign axi.wready  = en_q & ~w_held_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = en_q & ~ar_pend_q & ~rvalid_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  // Write path next state: capture AW/W independently, respond once both are held.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (axi.awvalid && axi.awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = axi.awaddr;
    end
    if (axi.wvalid && axi.wready) begin
      w_held_d = 1'b1;
      wdata_d  = axi.wdata;
      wstrb_d  = axi.wstrb;
    end
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (bvalid_q && axi.bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Read path next state: the array is sampled on the edge after AR, so a
  // same-edge write is not yet visible and the old word is returned.
  always_comb begin
    ar_pend_d = ar_pend_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (axi.arvalid && axi.arready) begin
      ar_pend_d = 1'b1;
      araddr_d  = axi.araddr;
    end
    if (ar_pend_q) begin
      ar_pend_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_ok ? mem_q[rd_idx[IW-1:0]] : '0;
      rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (rvalid_q && axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Control and channel registers; reset abandons any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q      <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      ar_pend_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      en_q      <= 1'b1;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ar_pend_q <= ar_pend_d;
      araddr_q  <= araddr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Byte-masked memory update; out-of-range writes only produce a response.
  always_ff @(posedge aclk) begin
    if (aresetn && wr_commit && wr_ok) begin
      for (int b = 0; b < SB; b++) begin
        if (wstrb_q[b]) begin
          mem_q[wr_idx[IW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wrapper.sv
// Directed bench for mem_wrapper: handshakes, latencies, strobes, offset/range, backpressure, reset.
// Latency: checks bvalid/rvalid timing against the edge-by-edge expectations.
// Backpressure: holds bready/rready low to check response stability.
module tb_mem_wrapper;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] offset = '0;
  int            errors = 0;
  int            checks = 0;

  axi4_lite_if #(.AW(AW), .DW(DW)) axi_bus ();

  mem_wrapper #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (axi_bus),
    .offset  (offset)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    axi_bus.awaddr = addr; axi_bus.wdata = data; axi_bus.wstrb = strb;
    axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = axi_bus.awvalid & axi_bus.awready;
      w_hs  = axi_bus.wvalid & axi_bus.wready;
      tick();
      n++;
      if (aw_hs) begin axi_bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin axi_bus.wvalid = 1'b0;  w_done = 1;  end
    end
    axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0;
    chk1({tag, " handshake"}, aw_done & w_done, 1'b1);
    chk1({tag, " bvalid early"}, axi_bus.bvalid, 1'b0);
    tick();
    chk1({tag, " bvalid"}, axi_bus.bvalid, 1'b1);
    chk({tag, " bresp"}, 32'(axi_bus.bresp), 32'(exp_resp));
    axi_bus.bready = 1'b1;
    tick();
    axi_bus.bready = 1'b0;
    chk1({tag, " bvalid clear"}, axi_bus.bvalid, 1'b0);
    chk1({tag, " awready back"}, axi_bus.awready, 1'b1);
  endtask

  task automatic read_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    bit done, hs;
    int n;
    done = 0; n = 0;
    axi_bus.araddr = addr; axi_bus.arvalid = 1'b1;
    while (!done && n < 20) begin
      hs = axi_bus.arvalid & axi_bus.arready;
      tick();
      n++;
      if (hs) done = 1;
    end
    axi_bus.arvalid = 1'b0;
    chk1({tag, " handshake"}, done, 1'b1);
    chk1({tag, " rvalid early"}, axi_bus.rvalid, 1'b0);
    tick();
    chk1({tag, " rvalid"}, axi_bus.rvalid, 1'b1);
    chk({tag, " rdata"}, axi_bus.rdata, exp_data);
    chk({tag, " rresp"}, 32'(axi_bus.rresp), 32'(exp_resp));
    axi_bus.rready = 1'b1;
    tick();
    axi_bus.rready = 1'b0;
    chk1({tag, " rvalid clear"}, axi_bus.rvalid, 1'b0);
    chk1({tag, " arready back"}, axi_bus.arready, 1'b1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk1({tag, " awready"}, axi_bus.awready, 1'b0);
    chk1({tag, " wready"},  axi_bus.wready,  1'b0);
    chk1({tag, " arready"}, axi_bus.arready, 1'b0);
    chk1({tag, " bvalid"},  axi_bus.bvalid,  1'b0);
    chk1({tag, " rvalid"},  axi_bus.rvalid,  1'b0);
    chk({tag, " bresp"}, 32'(axi_bus.bresp), 32'd0);
    chk({tag, " rresp"}, 32'(axi_bus.rresp), 32'd0);
    chk({tag, " rdata"}, axi_bus.rdata, 32'd0);
  endtask

  task automatic chk_readies(input string tag);
    chk1({tag, " awready"}, axi_bus.awready, 1'b1);
    chk1({tag, " wready"},  axi_bus.wready,  1'b1);
    chk1({tag, " arready"}, axi_bus.arready, 1'b1);
  endtask

  initial begin
    axi_bus.awvalid = 1'b0; axi_bus.awaddr = '0; axi_bus.awprot = 3'b000;
    axi_bus.wvalid  = 1'b0; axi_bus.wdata  = '0; axi_bus.wstrb  = '0;
    axi_bus.bready  = 1'b0;
    axi_bus.arvalid = 1'b0; axi_bus.araddr = '0; axi_bus.arprot = 3'b000;
    axi_bus.rready  = 1'b0;

    // Reset state and release.
    repeat (2) tick();
    chk_idle_zero("reset");
    aresetn = 1'b1;
    chk1("pre-edge awready", axi_bus.awready, 1'b0);
    tick();
    chk_readies("post-reset");

    // Power-up contents are zero.
    read_txn("init word", 32'h40, 32'h0, 2'b00);

    // Joint AW/W write then read back.
    axi_bus.awprot = 3'b111; axi_bus.arprot = 3'b101;
    write_txn("wr 0x0", 32'h0, 32'hDEADBEEF, 4'hF, 2'b00);
    read_txn("rd 0x0", 32'h0, 32'hDEADBEEF, 2'b00);

    // AW pulse three cycles ahead of a W pulse.
    axi_bus.awaddr = 32'h8; axi_bus.awvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    chk1("aw-first awready held", axi_bus.awready, 1'b0);
    tick();
    tick();
    chk1("aw-first no bvalid", axi_bus.bvalid, 1'b0);
    axi_bus.wdata = 32'h12345678; axi_bus.wstrb = 4'hF; axi_bus.wvalid = 1'b1;
    tick();
    axi_bus.wvalid = 1'b0;
    chk1("aw-first bvalid early", axi_bus.bvalid, 1'b0);
    tick();
    chk1("aw-first bvalid", axi_bus.bvalid, 1'b1);
    chk("aw-first bresp", 32'(axi_bus.bresp), 32'd0);
    axi_bus.bready = 1'b1; tick(); axi_bus.bready = 1'b0;
    read_txn("rd 0x8", 32'h8, 32'h12345678, 2'b00);

    // W pulse two cycles ahead of an AW pulse.
    axi_bus.wdata = 32'hA5A50F0F; axi_bus.wstrb = 4'hF; axi_bus.wvalid = 1'b1;
    tick();
    axi_bus.wvalid = 1'b0;
    chk1("w-first wready held", axi_bus.wready, 1'b0);
    tick();
    axi_bus.awaddr = 32'hC; axi_bus.awvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    tick();
    chk1("w-first bvalid", axi_bus.bvalid, 1'b1);
    axi_bus.bready = 1'b1; tick(); axi_bus.bready = 1'b0;
    read_txn("rd 0xC", 32'hC, 32'hA5A50F0F, 2'b00);

    // Byte strobes.
    write_txn("wr 0x4 full", 32'h4, 32'h11223344, 4'hF, 2'b00);
    write_txn("wr 0x4 strb", 32'h4, 32'hAABBCCDD, 4'b0101, 2'b00);
    read_txn("rd 0x4 merged", 32'h4, 32'h11BB33DD, 2'b00);

    // Write-response backpressure.
    axi_bus.awaddr = 32'h10; axi_bus.wdata = 32'h0000C0DE; axi_bus.wstrb = 4'hF;
    axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp bvalid held", axi_bus.bvalid, 1'b1);
      chk("bp bresp held", 32'(axi_bus.bresp), 32'd0);
      chk1("bp awready low", axi_bus.awready, 1'b0);
      tick();
    end
    axi_bus.bready = 1'b1; tick(); axi_bus.bready = 1'b0;
    chk1("bp bvalid clear", axi_bus.bvalid, 1'b0);
    chk1("bp awready back", axi_bus.awready, 1'b1);

    // Read-response backpressure.
    axi_bus.araddr = 32'h10; axi_bus.arvalid = 1'b1;
    tick();
    axi_bus.arvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp rvalid held", axi_bus.rvalid, 1'b1);
      chk("bp rdata held", axi_bus.rdata, 32'h0000C0DE);
      chk1("bp arready low", axi_bus.arready, 1'b0);
      tick();
    end
    axi_bus.rready = 1'b1; tick(); axi_bus.rready = 1'b0;
    chk1("bp rvalid clear", axi_bus.rvalid, 1'b0);
    chk1("bp arready back", axi_bus.arready, 1'b1);

    // Base offset and range limits.
    offset = 32'h1000;
    write_txn("off wr 0x1004", 32'h1004, 32'h00000055, 4'hF, 2'b00);
    read_txn("off rd 0x1004", 32'h1004, 32'h00000055, 2'b00);
    write_txn("oor wr", 32'h2000, 32'hCAFEF00D, 4'hF, 2'b10);
    read_txn("oor no alias", 32'h1000, 32'hDEADBEEF, 2'b00);
    read_txn("oor rd", 32'h2000, 32'h0, 2'b10);
    read_txn("last word", 32'h1FFC, 32'h0, 2'b00);
    read_txn("below base", 32'h0FFC, 32'h0, 2'b10);

    // Read and write of the same word completing together.
    axi_bus.awaddr = 32'h1008; axi_bus.wdata = 32'h0BADCAFE; axi_bus.wstrb = 4'hF;
    axi_bus.araddr = 32'h1008;
    axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1; axi_bus.arvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.arvalid = 1'b0;
    tick();
    chk1("same-edge bvalid", axi_bus.bvalid, 1'b1);
    chk1("same-edge rvalid", axi_bus.rvalid, 1'b1);
    chk("same-edge old data", axi_bus.rdata, 32'h12345678);
    axi_bus.bready = 1'b1; axi_bus.rready = 1'b1;
    tick();
    axi_bus.bready = 1'b0; axi_bus.rready = 1'b0;
    chk1("same-edge bvalid clear", axi_bus.bvalid, 1'b0);
    chk1("same-edge rvalid clear", axi_bus.rvalid, 1'b0);
    read_txn("same-edge new data", 32'h1008, 32'h0BADCAFE, 2'b00);

    // Reset in the middle of a write and a read.
    axi_bus.awaddr = 32'h100C; axi_bus.wdata = 32'h77777777; axi_bus.wstrb = 4'hF;
    axi_bus.araddr = 32'h1008;
    axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1; axi_bus.arvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.arvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk_idle_zero("mid-reset");
    tick();
    tick();
    chk_idle_zero("held-reset");
    aresetn = 1'b1;
    chk1("re-release arready", axi_bus.arready, 1'b0);
    tick();
    chk_readies("re-release");
    read_txn("abandoned write", 32'h100C, 32'hA5A50F0F, 2'b00);
    read_txn("kept 0x1008", 32'h1008, 32'h0BADCAFE, 2'b00);
    read_txn("kept 0x1000", 32'h1000, 32'hDEADBEEF, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wrapper.md
MEM_WRAPPER -- requirements
Module: mem_wrapper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named aclk and aresetn.
REQ-002 Parameter AW, default 32: AXI address width.
REQ-003 Parameter DW, default 32: AXI data width, a multiple of 8.
REQ-004 Parameter DEPTH, default 1024: memory size in DW-bit words.
REQ-005 Port aclk  input  1: clock; all logic is on the rising edge.
REQ-006 Port aresetn  input  1: asynchronous active-low reset.
REQ-007 Port axi  axi4_lite_if slave modport  AW/DW: slave side of all five AXI4-Lite channels (aw, w, b, ar, r).
REQ-008 Port offset  input  AW: base address subtracted from awaddr/araddr; static during operation.

Function
REQ-009 Byte offset = addr - offset, modulo 2^AW; word index = byte offset >> log2(DW/8); low address bits are ignored.
REQ-010 An access is in-range when word index < DEPTH; otherwise it is out-of-range.
REQ-011 awprot and arprot SHALL be ignored.
REQ-012 Write address channel: awready=1 when no write address is held; handshake awvalid&awready captures awaddr; awready=0 from the next cycle until the B handshake completes.
REQ-013 Write data channel: wready=1 when no write data is held; handshake wvalid&wready captures wdata/wstrb; wready=0 from the next cycle until the B handshake completes.
REQ-014 AW and W SHALL be accepted in either order or in the same cycle, and single-cycle valid pulses SHALL be accepted.
REQ-015 On the clock edge after both address and data are held, an in-range write SHALL update only the bytes whose wstrb bit is 1; bvalid SHALL rise on that same edge.
REQ-016 bresp SHALL be OKAY (2'b00) for in-range writes and SLVERR (2'b10) for out-of-range writes; out-of-range writes SHALL NOT modify memory.
REQ-017 bvalid SHALL stay 1, with bresp stable, until bvalid&bready; it clears on that edge, and awready/wready return to 1 on the same edge.
REQ-018 Read address channel: arready=1 when no read response is pending; arvalid&arready captures araddr.
REQ-019 rvalid SHALL rise one cycle after the AR handshake, with rdata = memory word and rresp OKAY for in-range reads.
REQ-020 Out-of-range reads SHALL return rdata=0 and rresp SLVERR.
REQ-021 arready=0 while rvalid=1; rvalid, rdata and rresp SHALL hold until rvalid&rready; rvalid clears and arready returns to 1 on that edge.
REQ-022 Read and write paths SHALL be independent and may complete in the same cycle.
REQ-023 A read of the word being written on the same edge SHALL return the pre-write data.
REQ-024 At most one outstanding transaction per direction (no pipelining).
REQ-025 Memory contents SHALL initialise to all zeros at power-up/configuration and SHALL NOT be cleared by aresetn.

Reset
REQ-026 While aresetn=0: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, and held address/data flags cleared.
REQ-027 On the first rising aclk edge after aresetn deasserts, awready, wready and arready SHALL go to 1.
REQ-028 If reset asserts mid-transaction, the transaction SHALL be abandoned with no partial write beyond what was already committed.

Verification
REQ-029 offset=0: write 0xDEADBEEF to 0x0 with wstrb=4'hF -> bvalid one cycle after the joint handshake, bresp=00; reading 0x0 -> rvalid one cycle after AR, rdata=0xDEADBEEF, rresp=00.
REQ-030 awvalid pulsed 3 cycles before wvalid, address 0x8, data 0x12345678 -> write completes after the W handshake; reading 0x8 returns 0x12345678.
REQ-031 Word at 0x4 = 0x11223344; write 0xAABBCCDD with wstrb=4'b0101 -> reading 0x4 returns 0x11BB33DD.
REQ-032 offset=0x1000: write 0x55 to 0x1004, then read 0x1004 -> 0x55; write to 0x1000+4*DEPTH -> bresp=10 and no memory change; read there -> rdata=0, rresp=10.
REQ-033 bready held 0 for 5 cycles after bvalid -> bvalid and bresp stable and awready=0 throughout; after bready=1, awready=1 on the next cycle. Same check for rready/rvalid/arready.
REQ-034 aresetn pulsed low mid-read and mid-write -> all valid/ready outputs 0 during reset, readies 1 one edge after release; previously written words are preserved.
